// File: rtl/fpnew_opgroup_issue_collector.sv
// fpnew_opgroup_issue_collector: steers issue handshakes to opgroup units and
// returns their results strictly in issue order via an order FIFO of unit indices.
module fpnew_opgroup_issue_collector #(
   parameter int unsigned NumUnits  = 4,
   parameter int unsigned Depth     = 8,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned TagWidth  = 1,
   localparam int unsigned UnitIdxW = $clog2(NumUnits),
   localparam int unsigned CntW     = $clog2(Depth + 1),
   localparam int unsigned PtrW     = $clog2(Depth)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               flush_i,
   input  logic                               in_valid_i,
   output logic                               in_ready_o,
   input  logic [UnitIdxW-1:0]                in_unit_i,
   output logic [NumUnits-1:0]                unit_in_valid_o,
   input  logic [NumUnits-1:0]                unit_in_ready_i,
   input  logic [NumUnits-1:0]                unit_out_valid_i,
   output logic [NumUnits-1:0]                unit_out_ready_o,
   input  logic [NumUnits-1:0][DataWidth-1:0] unit_result_i,
   input  logic [NumUnits-1:0][4:0]           unit_status_i,
   input  logic [NumUnits-1:0][TagWidth-1:0]  unit_tag_i,
   output logic                               out_valid_o,
   input  logic                               out_ready_i,
   output logic [DataWidth-1:0]               result_o,
   output logic [4:0]                         status_o,
   output logic [TagWidth-1:0]                tag_o,
   output logic [UnitIdxW-1:0]                out_unit_o,
   output logic [CntW-1:0]                    outstanding_o,
   output logic                               busy_o
);
   logic [UnitIdxW-1:0] order_q [Depth];
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]     count_q;
   logic                full, empty, idx_ok, iss_ok, push, rd_ok, pop;
   logic [UnitIdxW-1:0] head;
   assign full   = count_q == CntW'(Depth);
   assign empty  = count_q == '0;
   assign idx_ok = 32'(in_unit_i) < NumUnits;
   // rst_i only gates the visible handshakes; the pointers are held by the async clear
   assign iss_ok          = in_valid_i & ~full & ~flush_i & idx_ok;
   assign push            = iss_ok & unit_in_ready_i[in_unit_i];
   assign in_ready_o      = push & ~rst_i;
   assign unit_in_valid_o = (iss_ok & ~rst_i) ? NumUnits'(1) << in_unit_i : '0;
   assign head             = order_q[rd_ptr_q];
   assign rd_ok            = ~empty & ~flush_i;
   assign out_valid_o      = rd_ok & unit_out_valid_i[head];
   assign pop              = out_valid_o & out_ready_i;
   assign unit_out_ready_o = (rd_ok & out_ready_i) ? NumUnits'(1) << head : '0;
   assign result_o         = unit_result_i[head];
   assign status_o         = unit_status_i[head];
   assign tag_o            = unit_tag_i[head];
   assign out_unit_o       = head;
   assign outstanding_o    = count_q;
   assign busy_o           = ~empty;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PtrW'(push);
         rd_ptr_q <= rd_ptr_q + PtrW'(pop);
         count_q  <= count_q + CntW'(push) - CntW'(pop);
      end
   end
   always_ff @(posedge clk_i)
      if (push) order_q[wr_ptr_q] <= in_unit_i;
endmodule

// File: doc/fpnew_opgroup_issue_collector.md
Name: fpnew_opgroup_issue_collector

Overview:
- Initiator-side counterpart to the opgroup blocks.
- Accepts a single issue stream and steers each op's valid/ready handshake to one of NumUnits opgroup blocks.
- Records the target of each accepted op in an order FIFO, then returns the units' results strictly in issue order.
- Sits between the FPU front-end and the opgroup blocks. Operand fan-out is done by the parent; this block handles handshakes, ordering and result muxing only.

Parameters:
- NumUnits, 4, number of opgroup blocks served (2..8)
- Depth, 8, order FIFO entries, i.e. maximum ops in flight (power of 2, >=2)
- DataWidth, 64, result width
- TagWidth, 1, tag width
- UnitIdxW, $clog2(NumUnits), derived, do not override

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  drop all in-flight ordering state
- in_valid_i  in  1  issue request valid
- in_ready_o  out  1  issue request accepted
- in_unit_i  in  UnitIdxW  target unit index
- unit_in_valid_o  out  NumUnits  per-unit issue valid
- unit_in_ready_i  in  NumUnits  per-unit issue ready
- unit_out_valid_i  in  NumUnits  per-unit result valid
- unit_out_ready_o  out  NumUnits  per-unit result ready
- unit_result_i  in  NumUnits x DataWidth  per-unit result
- unit_status_i  in  NumUnits x 5  per-unit status {NV,DZ,OF,UF,NX}
- unit_tag_i  in  NumUnits x TagWidth  per-unit tag
- out_valid_o  out  1  ordered result valid
- out_ready_i  in  1  downstream ready
- result_o  out  DataWidth  ordered result
- status_o  out  5  ordered status
- tag_o  out  TagWidth  ordered tag
- out_unit_o  out  UnitIdxW  unit that produced result_o
- outstanding_o  out  $clog2(Depth+1)  ops in flight
- busy_o  out  1  outstanding_o != 0

Behaviour:
- Reset (rst_i high, asynchronous):
  - FIFO pointers and count go to 0.
  - Outputs: out_valid_o=0, in_ready_o=0, all unit_*_o=0, busy_o=0, outstanding_o=0.
  - result_o, status_o and tag_o are don't-care while out_valid_o=0.
- Signals used below:
  - full = (count==Depth); empty = (count==0).
  - idx_ok = (in_unit_i < NumUnits).
- Issue side (combinational):
  - unit_in_valid_o[k] = in_valid_i & !full & !flush_i & idx_ok & (in_unit_i==k).
  - in_ready_o = in_valid_i & !full & !flush_i & idx_ok & unit_in_ready_i[in_unit_i].
  - Push on in_valid_i & in_ready_o: write in_unit_i at the write pointer, then advance it.
  - in_ready_o does not depend on a same-cycle pop. A full FIFO blocks issue even if a pop happens that cycle.
  - An out-of-range in_unit_i is never accepted and stalls the issue stream. Asserting it is a protocol violation; verification flags it with an assertion.
- Result side (combinational):
  - h = FIFO head entry.
  - out_valid_o = !empty & !flush_i & unit_out_valid_i[h].
  - unit_out_ready_o[k] = !empty & !flush_i & (k==h) & out_ready_i.
  - result_o, status_o, tag_o and out_unit_o are muxed from unit h.
  - Pop on out_valid_o & out_ready_i: advance the read pointer.
  - A non-head unit with a valid result is held (its ready stays 0) until it becomes head. No result is ever dropped or reordered.
- Latency and throughput:
  - No bypass. An op issued in cycle N reaches the output no earlier than cycle N+1, even from a combinational (0-stage) unit; that unit holds its result for one cycle.
  - Sustained throughput is 1 op per cycle when units are ready.
- Count and wrap-around:
  - Count updates +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Pointers wrap modulo Depth.
  - outstanding_o = count (registered). busy_o = (count!=0).
- Flush:
  - While flush_i is high: all handshakes toward units and downstream are masked to 0.
  - At the next edge, pointers and count clear to 0.
  - The opgroup blocks see the same flush_i and discard their own state.
  - Issue resumes the cycle after flush_i deasserts.
- Units must return their own results in their own issue order. Collector ordering relies on this.
- Simultaneous push and pop when full is impossible because push is blocked. When empty, pop is impossible.

Test Plan:
- Reset: rst_i high mid-traffic with count=3 -> outstanding_o=0, busy_o=0, out_valid_o=0 immediately; after release, first issue is accepted in the first cycle.
- Reordering: issue unit 2 (4-cycle latency), then unit 0 (1-cycle latency) -> unit 0's result is held with unit_out_ready_o[0]=0 until unit 2's result pops; output order is unit 2 then unit 0, out_unit_o=2 then 0.
- Full: Depth=8, out_ready_i=0, continuous issue -> 8 accepts, then in_ready_o=0 with outstanding_o=8; a single pop re-enables issue the following cycle, not the same cycle.
- Back-to-back streaming: 100 ops round-robin over units 0..3, all ready -> 1 result per cycle after fill, tags match issue order, no bubbles.
- Zero-latency unit: issue to a combinational unit in cycle N -> out_valid_o asserts in cycle N+1 with the correct result_o and status_o.
- Flush: flush_i for 1 cycle with 5 ops outstanding -> no handshakes during flush, outstanding_o=0 the next cycle, the next issue is accepted normally.
